// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Shares one SPI master byte engine among N_REQ requesters. Arbitration is
//   round-robin, and each grant carries exactly one byte. The arbiter inserts
//   an idle gap after every frame and aborts a frame that the engine does not
//   complete in time.
// Ports
//   clk, reset             clock, synchronous active-high reset
//   req / req_data         per-requester level request and tx byte ([8*i+7:8*i])
//   ack / err              one-cycle completion / abort pulse to the owner
//   rx_data                MISO byte, updated in the ack cycle and held
//   grant                  one-hot owner, high from START through WAIT_DONE
//   spi_start/spi_tx_data  start pulse and tx byte to the byte engine
//   spi_busy/spi_done/spi_rx_data  engine status, completion pulse, rx byte
module spi_txn_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   err,
  output logic [7:0]         rx_data,
  output logic [N_REQ-1:0]   grant,
  output logic               spi_start,
  output logic [7:0]         spi_tx_data,
  input  logic               spi_busy,
  input  logic               spi_done,
  input  logic [7:0]         spi_rx_data
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_GAP} state_t;

  state_t state, state_nx;

  logic [IW-1:0]    rr_ptr, rr_ptr_nx;
  logic [IW-1:0]    win_idx;
  logic             win_found;
  logic [TW-1:0]    to_cnt, to_cnt_nx;
  logic [GW-1:0]    gap_cnt, gap_cnt_nx;
  logic             timeout_hit, gap_done;

  logic [N_REQ-1:0] ack_nx, err_nx, grant_nx;
  logic             start_nx;
  logic [7:0]       tx_nx, rx_nx;

  // Round-robin search: first requester at or after rr_ptr, wrapping around.
  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  // to_cnt counts WAIT_DONE cycles already spent. Expiry fires in the cycle
  // whose increment would bring it to TIMEOUT-1, so WAIT_DONE lasts at most
  // TIMEOUT-1 cycles and err lands TIMEOUT cycles after spi_start.
  assign timeout_hit = (to_cnt == TW'(TIMEOUT - 2));
  // GAP covers the ack/err cycle plus GAP_CYCLES further cycles.
  assign gap_done    = (gap_cnt == GW'(GAP_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:      if (win_found && !spi_busy) state_nx = S_START;
      S_START:     state_nx = S_WAIT_DONE;
      S_WAIT_DONE: if (spi_done || timeout_hit) state_nx = S_GAP;
      S_GAP:       if (gap_done) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ack_nx     = '0;
    err_nx     = '0;
    start_nx   = 1'b0;
    grant_nx   = grant;
    tx_nx      = spi_tx_data;
    rx_nx      = rx_data;
    rr_ptr_nx  = rr_ptr;
    to_cnt_nx  = to_cnt;
    gap_cnt_nx = gap_cnt;
    unique case (state)
      S_IDLE: begin
        if (win_found && !spi_busy) begin
          start_nx = 1'b1;
          for (int unsigned i = 0; i < N_REQ; i++) grant_nx[i] = (win_idx == IW'(i));
          tx_nx     = req_data[{win_idx, 3'b000} +: 8];
          rr_ptr_nx = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      S_START: to_cnt_nx = '0;
      S_WAIT_DONE: begin
        // A done arriving in the expiry cycle takes priority over the abort.
        if (spi_done) begin
          ack_nx     = grant;
          rx_nx      = spi_rx_data;
          grant_nx   = '0;
          gap_cnt_nx = '0;
        end else if (timeout_hit) begin
          err_nx     = grant;
          grant_nx   = '0;
          gap_cnt_nx = '0;
        end else begin
          to_cnt_nx = to_cnt + 1'b1;
        end
      end
      S_GAP: if (!gap_done) gap_cnt_nx = gap_cnt + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack         <= '0;
      err         <= '0;
      grant       <= '0;
      spi_start   <= 1'b0;
      spi_tx_data <= '0;
      rx_data     <= '0;
      rr_ptr      <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      ack         <= ack_nx;
      err         <= err_nx;
      grant       <= grant_nx;
      spi_start   <= start_nx;
      spi_tx_data <= tx_nx;
      rx_data     <= rx_nx;
      rr_ptr      <= rr_ptr_nx;
      to_cnt      <= to_cnt_nx;
      gap_cnt     <= gap_cnt_nx;
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Testbench for spi_txn_arbiter: directed table of single frames, hand-written
// reset/ignore sequences, then randomized traffic against a frame-level model.
module tb_spi_txn_arbiter;

  localparam int unsigned N_REQ      = 2;
  localparam int unsigned GAP_CYCLES = 4;
  localparam int unsigned TIMEOUT    = 32;

  logic        clk, reset;
  logic [1:0]  req, ack, err, grant;
  logic [15:0] req_data;
  logic [7:0]  rx_data, spi_tx_data, spi_rx_data;
  logic        spi_start, spi_busy, spi_done;

  int unsigned n_cmp, n_bad;

  spi_txn_arbiter #(.N_REQ(N_REQ), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .rx_data(rx_data), .grant(grant),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data),
    .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx_data(spi_rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  d0, d1;
    int unsigned busy_cyc;
    int unsigned delay;      // cycles from spi_start to spi_done
    logic [7:0]  rx;
    logic        hold;       // keep req high after ack/err
    logic [1:0]  e_grant;
    logic [7:0]  e_tx;
    logic [1:0]  e_ack, e_err;
    logic [7:0]  e_rx;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Entered at the falling edge of a cycle in which the DUT is IDLE.
  task automatic run_vec(input vec_t v);
    int unsigned d_end;
    d_end    = (v.delay <= TIMEOUT - 1) ? v.delay + 1 : TIMEOUT;
    req      = v.req;
    req_data = {v.d1, v.d0};
    spi_done = 1'b0;
    spi_busy = (v.busy_cyc != 0);
    for (int unsigned b = 1; b <= v.busy_cyc; b++) begin
      @(negedge clk);
      chk("busy_blocks", 32'({spi_start, grant}), 32'd0);
      if (b == v.busy_cyc) spi_busy = 1'b0;
    end
    @(negedge clk);
    chk("start", 32'({spi_start, grant, spi_tx_data, ack, err}), 32'({1'b1, v.e_grant, v.e_tx, 4'b0}));
    req_data = 16'($urandom);
    for (int unsigned k = 1; k <= d_end + GAP_CYCLES + 1; k++) begin
      @(negedge clk);
      if (k < d_end)
        chk("wait", 32'({spi_start, grant, spi_tx_data, ack, err}), 32'({1'b0, v.e_grant, v.e_tx, 4'b0}));
      else if (k == d_end)
        chk("ack_err", 32'({ack, err, grant, spi_start, rx_data}), 32'({v.e_ack, v.e_err, 3'b0, v.e_rx}));
      else
        chk("gap", 32'({ack, err, grant, spi_start, spi_tx_data, rx_data}), 32'({7'b0, v.e_tx, v.e_rx}));
      spi_done    = (k == v.delay);
      spi_rx_data = (k == v.delay) ? v.rx : 8'($urandom);
      if (k == d_end && !v.hold) req = 2'b00;
      if (k > d_end) req_data = 16'($urandom);
    end
    spi_done = 1'b0;
  endtask

  // Frame-level reference model state for the random phase.
  logic        m_act, m_ok;
  int unsigned m_rr, m_owner, m_s, m_e, m_done_at, m_idle_at;
  logic [7:0]  m_tx, m_rx, exp_tx, exp_rx;
  logic [1:0]  x_ack, x_err, x_grant, one;
  int unsigned d, w, r;

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; req = '0; req_data = '0; spi_busy = 1'b0; spi_done = 1'b0; spi_rx_data = '0;

    //            req    d0     d1     busy dly rx     hold grant  tx     ack    err    rx_data
    tbl[0]  = '{2'b01, 8'hA5, 8'h00, 0,  16, 8'h3C, 1'b0, 2'b01, 8'hA5, 2'b01, 2'b00, 8'h3C};
    tbl[1]  = '{2'b10, 8'h00, 8'h5A, 0,  3,  8'h77, 1'b0, 2'b10, 8'h5A, 2'b10, 2'b00, 8'h77};
    tbl[2]  = '{2'b11, 8'h11, 8'h22, 0,  4,  8'h01, 1'b1, 2'b01, 8'h11, 2'b01, 2'b00, 8'h01};
    tbl[3]  = '{2'b11, 8'h11, 8'h22, 0,  4,  8'h02, 1'b1, 2'b10, 8'h22, 2'b10, 2'b00, 8'h02};
    tbl[4]  = '{2'b11, 8'h11, 8'h22, 0,  4,  8'h03, 1'b1, 2'b01, 8'h11, 2'b01, 2'b00, 8'h03};
    tbl[5]  = '{2'b11, 8'h11, 8'h22, 0,  4,  8'h04, 1'b0, 2'b10, 8'h22, 2'b10, 2'b00, 8'h04};
    tbl[6]  = '{2'b10, 8'h00, 8'hC9, 0,  99, 8'hFF, 1'b0, 2'b10, 8'hC9, 2'b00, 2'b10, 8'h04};
    tbl[7]  = '{2'b01, 8'h6E, 8'h00, 0,  31, 8'h9D, 1'b0, 2'b01, 8'h6E, 2'b01, 2'b00, 8'h9D};
    tbl[8]  = '{2'b01, 8'hB2, 8'h00, 0,  32, 8'h44, 1'b0, 2'b01, 8'hB2, 2'b00, 2'b01, 8'h9D};
    tbl[9]  = '{2'b01, 8'hD4, 8'h00, 50, 1,  8'h5E, 1'b0, 2'b01, 8'hD4, 2'b01, 2'b00, 8'h5E};
    tbl[10] = '{2'b11, 8'h71, 8'h17, 0,  2,  8'h88, 1'b0, 2'b10, 8'h17, 2'b10, 2'b00, 8'h88};

    repeat (3) @(negedge clk);
    chk("reset_state", 32'({ack, err, grant, spi_start, spi_tx_data, rx_data}), 32'd0);
    reset = 1'b0;

    for (int unsigned i = 0; i < 11; i++) run_vec(tbl[i]);

    // Reset in WAIT_DONE, then the pointer must restart at requester 0.
    req = 2'b01; req_data = 16'h00C3;
    @(negedge clk);
    chk("t5_start", 32'({spi_start, grant, spi_tx_data}), 32'({1'b1, 2'b01, 8'hC3}));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_reset", 32'({ack, err, grant, spi_start, spi_tx_data, rx_data}), 32'd0);
    req = 2'b11; req_data = 16'h2211;
    @(negedge clk);
    chk("t5_rr_restart", 32'({spi_start, grant, spi_tx_data}), 32'({1'b1, 2'b01, 8'h11}));
    spi_done = 1'b1; spi_rx_data = 8'h5A;
    @(negedge clk);
    spi_done = 1'b0;
    chk("done_in_start_ignored", 32'({grant, ack, err}), 32'({2'b01, 4'b0}));
    spi_done = 1'b1; spi_rx_data = 8'hE7;
    @(negedge clk);
    spi_done = 1'b0; req = 2'b00;
    chk("t5_ack", 32'({ack, err, grant, rx_data}), 32'({2'b01, 4'b0, 8'hE7}));
    repeat (GAP_CYCLES + 1) @(negedge clk);

    // Randomized traffic against the frame-level model.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_act = 1'b0; m_ok = 1'b0; m_rr = 0; m_idle_at = 0; m_owner = 0;
    m_s = 0; m_e = 0; m_done_at = 0; m_tx = '0; m_rx = '0; exp_tx = '0; exp_rx = '0;
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      if (m_act && cyc == m_s) exp_tx = m_tx;
      if (m_act && cyc == m_e && m_ok) exp_rx = m_rx;
      one     = 2'(1 << m_owner);
      x_grant = (m_act && cyc >= m_s && cyc < m_e) ? one : 2'b00;
      x_ack   = (m_act && cyc == m_e && m_ok)  ? one : 2'b00;
      x_err   = (m_act && cyc == m_e && !m_ok) ? one : 2'b00;
      chk("rand", 32'({ack, err, grant, spi_start, spi_tx_data, rx_data}),
          32'({x_ack, x_err, x_grant, (m_act && cyc == m_s), exp_tx, exp_rx}));

      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req[i]) begin
          if (m_act && cyc == m_e && m_owner == i && $urandom_range(0, 3) != 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 1) == 1) req_data = 16'($urandom);
      spi_busy    = ($urandom_range(0, 3) == 0);
      spi_rx_data = 8'($urandom);
      if (m_act && cyc == m_done_at) begin
        spi_done = 1'b1;
        m_rx     = spi_rx_data;
      end else if (m_act && cyc > m_s && cyc < m_e) begin
        spi_done = 1'b0;
      end else begin
        spi_done = ($urandom_range(0, 7) == 0);
      end

      if (cyc >= m_idle_at && req != 2'b00 && !spi_busy) begin
        w = N_REQ;
        for (int unsigned k = 0; k < N_REQ; k++)
          if (w == N_REQ && req[(m_rr + k) % N_REQ]) w = (m_rr + k) % N_REQ;
        r = $urandom_range(0, 9);
        if (r < 6)      d = $urandom_range(1, 8);
        else if (r < 8) d = $urandom_range(30, 33);
        else            d = $urandom_range(1, 36);
        m_act     = 1'b1;
        m_owner   = w;
        m_s       = cyc + 1;
        m_tx      = req_data[8*w +: 8];
        m_done_at = m_s + d;
        m_ok      = (d <= TIMEOUT - 1);
        m_e       = m_ok ? m_done_at + 1 : m_s + TIMEOUT;
        m_idle_at = m_e + GAP_CYCLES + 1;
        m_rr      = (w + 1) % N_REQ;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
